// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - single-port memory arbiter between instruction fetch and load/store ports
// D normally wins conflicts; a saturating starvation counter forces an I grant after STARVE_MAX denials.
module imem_dmem_arbiter #(
  parameter int AW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_wstrb,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    starve_cnt
);

  localparam logic [1:0] CNT_MAX = 2'(STARVE_MAX);

  logic       resp_v;
  logic       resp_is_d;
  logic [1:0] cnt;
  logic       i_win;
  logic       d_store;

  // Grants are gated by rst_n so nothing is issued while reset is held low.
  assign i_win   = i_req & (~d_req | (cnt == CNT_MAX));
  assign i_gnt   = rst_n & i_win;
  assign d_gnt   = rst_n & d_req & ~i_win;
  assign d_store = d_gnt & d_we;

  assign mem_en    = i_gnt | d_gnt;
  assign mem_we    = d_store;
  assign mem_addr  = d_gnt ? d_addr : i_addr;
  assign mem_wdata = d_wdata;
  assign mem_wstrb = d_store ? d_wstrb : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 2'd0;
      resp_v    <= 1'b0;
      resp_is_d <= 1'b0;
    end else begin
      resp_v    <= i_gnt | d_gnt;
      resp_is_d <= d_gnt;
      if (i_gnt) begin
        cnt <= 2'd0;
      end else if (i_req && (cnt != CNT_MAX)) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  assign i_rvalid   = resp_v & ~resp_is_d;
  assign d_rvalid   = resp_v & resp_is_d;
  assign i_rdata    = mem_rdata;
  assign d_rdata    = mem_rdata;
  assign starve_cnt = cnt;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - self-checking bench for imem_dmem_arbiter
// The bench plays the memory macro and keeps a word-level reference model of arbitration and contents.
module tb_imem_dmem_arbiter;
  localparam int AW         = 32;
  localparam int STARVE_MAX = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic [3:0]    d_wstrb = '0;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata = '0;
  logic [1:0]    starve_cnt;

  imem_dmem_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    case (i)
      0:       return 32'h00a00093;
      1:       return 32'h01400113;
      2:       return 32'hffb00193;
      default: return 32'(i) * 32'h9E3779B1;
    endcase
  endfunction

  // Memory macro: 256 words, synchronous read data the cycle after mem_en.
  logic [31:0] mem [0:255];
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr[9:2]];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [0:255];
  int          m_denied = 0;
  bit          m_pv = 0, m_pd = 0, m_pload = 0;
  logic [31:0] m_pdata = '0;
  logic [31:0] last_i = '0, last_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model at negedge, then advance the model.
  task automatic tick(output bit gi, output bit gd, output logic [1:0] sc);
    bit ei, ed;
    @(negedge clk);
    ei = i_req && (!d_req || m_denied == STARVE_MAX);
    ed = d_req && !ei;
    chk("i_gnt", 32'(i_gnt), 32'(ei));
    chk("d_gnt", 32'(d_gnt), 32'(ed));
    chk("mem_en", 32'(mem_en), 32'(ei | ed));
    chk("starve_cnt", 32'(starve_cnt), 32'(m_denied));
    if (ei) begin
      chk("mem_addr_i", mem_addr, i_addr);
      chk("mem_we_i", 32'(mem_we), 32'd0);
      chk("mem_wstrb_i", 32'(mem_wstrb), 32'd0);
    end
    if (ed) begin
      chk("mem_addr_d", mem_addr, d_addr);
      chk("mem_we_d", 32'(mem_we), 32'(d_we));
      chk("mem_wstrb_d", 32'(mem_wstrb), d_we ? 32'(d_wstrb) : 32'd0);
      if (d_we) chk("mem_wdata", mem_wdata, d_wdata);
    end
    chk("i_rvalid", 32'(i_rvalid), 32'(m_pv && !m_pd));
    chk("d_rvalid", 32'(d_rvalid), 32'(m_pv && m_pd));
    chk("rvalid_excl", 32'(i_rvalid & d_rvalid), 32'd0);
    if (m_pv && !m_pd) chk("i_rdata", i_rdata, m_pdata);
    if (m_pv && m_pd && m_pload) chk("d_rdata", d_rdata, m_pdata);
    if (i_rvalid) last_i = i_rdata;
    if (d_rvalid) last_d = d_rdata;
    gi = i_gnt;
    gd = d_gnt;
    sc = starve_cnt;
    m_pv    = ei | ed;
    m_pd    = ed;
    m_pload = ei | (ed & !d_we);
    if (ei) m_pdata = ref_mem[i_addr[9:2]];
    else if (ed && !d_we) m_pdata = ref_mem[d_addr[9:2]];
    if (ed && d_we)
      for (int b = 0; b < 4; b++)
        if (d_wstrb[b]) ref_mem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
    if (ei) m_denied = 0;
    else if (i_req && m_denied < STARVE_MAX) m_denied++;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_chk();
    @(negedge clk);
    chk("rst_i_gnt", 32'(i_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_starve_cnt", 32'(starve_cnt), 32'd0);
    m_denied = 0;
    m_pv = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit gi, gd;
    logic [1:0] sc;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    // Reset with both requests high: nothing may be granted.
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 3; k++) rst_chk();
    preload = 1'b0;
    rst_n = 1'b1;
    i_req = 1'b0; d_req = 1'b0;
    tick(gi, gd, sc);

    // 1: back-to-back fetches.
    for (int k = 0; k < 4; k++) begin
      i_req  = (k < 3);
      i_addr = 32'(4 * k);
      tick(gi, gd, sc);
      if (k > 0) chk("t1_word", last_i, init_word(k - 1));
    end

    // 2: store then load of the same word.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    tick(gi, gd, sc);
    d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
    tick(gi, gd, sc);
    d_req = 1'b0;
    tick(gi, gd, sc);
    chk("t2_load", last_d, 32'hDEADBEEF);

    // 3: sustained conflict gives D,D,D,I repeating.
    i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      d_addr = 32'(32'h200 + 4 * k);
      tick(gi, gd, sc);
      chk("t3_i_gnt", 32'(gi), 32'(k % 4 == 3));
      chk("t3_cnt", 32'(sc), 32'(k % 4));
      if (gi) i_addr = i_addr + 32'd4;
    end
    i_req = 1'b0; d_req = 1'b0;
    tick(gi, gd, sc);

    // 4: alternating I/D grants, responses back-to-back.
    for (int k = 0; k < 8; k++) begin
      i_req = (k % 2 == 0); d_req = (k % 2 == 1);
      i_addr = 32'(8 * k); d_addr = 32'(32'h300 + 8 * k); d_we = 1'b0;
      tick(gi, gd, sc);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick(gi, gd, sc);

    // 5: reset in the cycle after a load grant drops the response.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    tick(gi, gd, sc);
    chk("t5_d_gnt", 32'(gd), 32'd1);
    rst_n = 1'b0;
    i_req = 1'b1; i_addr = 32'h0;
    rst_chk();
    rst_chk();
    rst_n = 1'b1; d_req = 1'b0;
    tick(gi, gd, sc);
    chk("t5_first_gnt", 32'(gi), 32'd1);
    i_req = 1'b0;
    tick(gi, gd, sc);

    // 6: byte store merged into an instruction word.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h0000AB00; d_wstrb = 4'b0010;
    tick(gi, gd, sc);
    d_req = 1'b0; d_we = 1'b0; i_req = 1'b1; i_addr = 32'h0;
    tick(gi, gd, sc);
    i_req = 1'b0;
    tick(gi, gd, sc);
    chk("t6_merged", last_i, 32'h00a0ab93);

    // Random traffic; each requester holds its request until granted.
    for (int n = 0; n < 400; n++) begin
      tick(gi, gd, sc);
      if (!i_req || gi) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!d_req || gd) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        d_wdata = $urandom;
        d_wstrb = 4'($urandom_range(0, 15));
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick(gi, gd, sc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
